// File: rtl/iob_native_mem_responder_pkg.sv
// Shared types and defaults for the IOb native memory responder.
// The FSM state encoding and the counter sizing helper live here.
package iob_native_mem_responder_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_MEM_ADDR_W  = 10;
  localparam int DEF_READ_LAT    = 1;
  localparam int DEF_WAIT_CYCLES = 0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RD   = 2'd2,
    ST_BUSY = 2'd3
  } state_e;

  // Wide enough to hold the larger of the read latency and the busy-cycle count.
  function automatic int cntWidth(input int readLat, input int waitCycles);
    int maxVal;
    int w;
    maxVal = (readLat > waitCycles) ? readLat : waitCycles;
    w = $clog2(maxVal + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iob_native_mem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only loads on a read access, so it holds the last word read.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                en_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   d_i,
  output logic [DATA_W-1:0]   d_o
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (we_i[b]) begin
          mem[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rdata_q <= '0;
    end else if (en_i && (we_i == '0)) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign d_o = rdata_q;

endmodule

// File: rtl/iob_native_mem_responder.sv
// IOb native bus responder: byte-writable RAM with programmable read latency and
// post-transfer busy cycles; ready, rvalid and rdata all come from registers.
module iob_native_mem_responder
  import iob_native_mem_responder_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int MEM_ADDR_W  = DEF_MEM_ADDR_W,
  parameter int READ_LAT    = DEF_READ_LAT,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                                  clk_i,
  input  logic                                  arst_i,
  input  logic                                  cke_i,
  input  logic [1+ADDR_W+DATA_W+DATA_W/8-1:0]   req_i,
  output logic [DATA_W+2-1:0]                   resp_o,
  output logic                                  drop_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int CNT_W  = cntWidth(READ_LAT, WAIT_CYCLES);

  logic                  avalid;
  logic [MEM_ADDR_W-1:0] wordIdx;
  logic [DATA_W-1:0]     wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  unusedReq;

  assign avalid    = req_i[REQ_W-1];
  assign wordIdx   = req_i[STRB_W+DATA_W+2 +: MEM_ADDR_W];
  assign wdata     = req_i[STRB_W +: DATA_W];
  assign wstrb     = req_i[STRB_W-1:0];
  assign unusedReq = ^req_i;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdataHold_q;
  logic              drop_q;
  logic              ready;
  logic              accept;
  logic              isWrite;
  logic [DATA_W-1:0] ramData;

  assign ready   = (state_q == ST_IDLE);
  assign accept  = cke_i & avalid & ready;
  assign isWrite = |wstrb;

  iob_ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (accept),
    .we_i   (wstrb),
    .addr_i (wordIdx),
    .d_i    (wdata),
    .d_o    (ramData)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (avalid) begin
          if (isWrite) begin
            if (WAIT_CYCLES > 0) begin
              state_d = ST_BUSY;
              cnt_d   = CNT_W'(WAIT_CYCLES);
            end
          end else begin
            state_d = ST_RD;
            cnt_d   = CNT_W'(READ_LAT - 1);
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          state_d = (WAIT_CYCLES > 0) ? ST_BUSY : ST_IDLE;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
    // The response cycle is the single cycle spent in RD with the counter at zero.
    rvalid_d = (state_d == ST_RD) && (cnt_d == '0);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      rdataHold_q <= '0;
      drop_q      <= 1'b0;
    end else if (cke_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      if (rvalid_q) begin
        rdataHold_q <= ramData;
      end
      if (avalid && !ready) begin
        drop_q <= 1'b1;
      end
    end
  end

  // Outside the response cycle rdata shows the word delivered by the previous response.
  assign resp_o = {(rvalid_q ? ramData : rdataHold_q), rvalid_q, ready};
  assign drop_o = drop_q;

endmodule
